// File: rtl/matmul_pin_driver.sv
// Host-side initiator for the 2x2 matrix-multiply pin protocol.
// It loads eight operand bytes, then steps through the four products and captures each result.
module matmul_pin_driver #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] operands,
    output logic        busy,
    output logic        done,
    output logic [16:0] c00,
    output logic [16:0] c01,
    output logic [16:0] c10,
    output logic [16:0] c11,
    output logic [2:0]  mm_sel_in,
    output logic [7:0]  mm_input_val,
    output logic        mm_execute,
    output logic [1:0]  mm_sel_out,
    input  logic [16:0] mm_result
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [63:0] shadow_q, shadow_d;
    logic [2:0]  slot_q, slot_d;
    logic [3:0]  settle_q, settle_d;
    logic [2:0]  sel_in_q, sel_in_d;
    logic [7:0]  val_q, val_d;
    logic        exec_q, exec_d;
    logic [1:0]  sel_out_q, sel_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [16:0] c_q [4];
    logic [16:0] c_d [4];

    logic [2:0]  slot_nxt;
    logic        settle_last;

    assign slot_nxt    = slot_q + 3'd1;
    assign settle_last = (settle_q == SETTLE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (slot_q == 3'd7) state_d = S_READ;
            S_READ:  if (settle_last && sel_out_q == 2'd3) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for every pin and capture register; pins are then driven from flops only.
    always_comb begin
        shadow_d  = shadow_q;
        slot_d    = slot_q;
        settle_d  = settle_q;
        sel_in_d  = sel_in_q;
        val_d     = val_q;
        exec_d    = exec_q;
        sel_out_d = sel_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        c_d       = c_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d = operands;
                    slot_d   = 3'd0;
                    sel_in_d = 3'd0;
                    val_d    = operands[7:0];
                    exec_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_LOAD: begin
                if (slot_q == 3'd7) begin
                    exec_d    = 1'b1;
                    sel_out_d = 2'd0;
                    settle_d  = 4'd0;
                end else begin
                    slot_d   = slot_nxt;
                    sel_in_d = slot_nxt;
                    val_d    = shadow_q[{slot_nxt, 3'b000} +: 8];
                end
            end
            S_READ: begin
                if (settle_last) begin
                    settle_d       = 4'd0;
                    c_d[sel_out_q] = mm_result;
                    if (sel_out_q == 2'd3) begin
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        sel_out_d = 2'd0;
                    end else begin
                        sel_out_d = sel_out_q + 2'd1;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q  <= '0;
            slot_q    <= '0;
            settle_q  <= '0;
            sel_in_q  <= '0;
            val_q     <= '0;
            exec_q    <= 1'b1;
            sel_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 4; i++) c_q[i] <= '0;
        end else begin
            shadow_q  <= shadow_d;
            slot_q    <= slot_d;
            settle_q  <= settle_d;
            sel_in_q  <= sel_in_d;
            val_q     <= val_d;
            exec_q    <= exec_d;
            sel_out_q <= sel_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < 4; i++) c_q[i] <= c_d[i];
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign c00          = c_q[0];
    assign c01          = c_q[1];
    assign c10          = c_q[2];
    assign c11          = c_q[3];
    assign mm_sel_in    = sel_in_q;
    assign mm_input_val = val_q;
    assign mm_execute   = exec_q;
    assign mm_sel_out   = sel_out_q;

endmodule

// File: tb/tb_matmul_pin_driver.sv
// Bench for matmul_pin_driver: three driver builds (SETTLE_CYCLES 2, 1 and 5), each wired to a behavioural 2x2 multiplier.
// The build with SETTLE_CYCLES=2 is compared every cycle against a model that tracks the cycle index of each run.
module tb_matmul_pin_driver;

    localparam int S0 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] operands;
    logic        start_v      [3];
    logic        busy_v       [3];
    logic        done_v       [3];
    logic [16:0] c00_v        [3];
    logic [16:0] c01_v        [3];
    logic [16:0] c10_v        [3];
    logic [16:0] c11_v        [3];
    logic [2:0]  mm_sel_in_v  [3];
    logic [7:0]  mm_input_val_v [3];
    logic        mm_execute_v [3];
    logic [1:0]  mm_sel_out_v [3];
    logic [16:0] mm_result_v  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        logic [7:0]  m [8];
        logic [16:0] mres;

        initial for (int i = 0; i < 8; i++) m[i] = 8'd0;

        always @(posedge clk) if (!mm_execute_v[g]) m[mm_sel_in_v[g]] <= mm_input_val_v[g];

        always_comb begin
            mres = 17'd0;
            case (mm_sel_out_v[g])
                2'd0: mres = 17'(m[0]) * 17'(m[4]) + 17'(m[1]) * 17'(m[6]);
                2'd1: mres = 17'(m[0]) * 17'(m[5]) + 17'(m[1]) * 17'(m[7]);
                2'd2: mres = 17'(m[2]) * 17'(m[4]) + 17'(m[3]) * 17'(m[6]);
                default: mres = 17'(m[2]) * 17'(m[5]) + 17'(m[3]) * 17'(m[7]);
            endcase
        end
        assign mm_result_v[g] = mm_execute_v[g] ? mres : 17'd0;

        matmul_pin_driver #(.SETTLE_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 5)) dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start_v[g]),
            .operands     (operands),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .c00          (c00_v[g]),
            .c01          (c01_v[g]),
            .c10          (c10_v[g]),
            .c11          (c11_v[g]),
            .mm_sel_in    (mm_sel_in_v[g]),
            .mm_input_val (mm_input_val_v[g]),
            .mm_execute   (mm_execute_v[g]),
            .mm_sel_out   (mm_sel_out_v[g]),
            .mm_result    (mm_result_v[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input int a00, a01, a10, a11, b00, b01, b10, b11);
        return {8'(b11), 8'(b10), 8'(b01), 8'(b00), 8'(a11), 8'(a10), 8'(a01), 8'(a00)};
    endfunction

    function automatic logic [7:0] byte_of(input logic [63:0] v, input int k);
        logic [63:0] s;
        s = v >> (8 * k);
        return s[7:0];
    endfunction

    // C[i][j] = sum_k A[i][k] * B[k][j], with A bytes 0..3 and B bytes 4..7 in row-major order.
    function automatic int c_entry(input logic [63:0] v, input int n);
        int i, j, s;
        i = n / 2;
        j = n % 2;
        s = 0;
        for (int k = 0; k < 2; k++)
            s += int'(byte_of(v, 2 * i + k)) * int'(byte_of(v, 4 + 2 * k + j));
        return s;
    endfunction

    // Model: t is the cycle number within a run (0 = idle, 1..8 load, 9..8+4S read, 9+4S done).
    int          t = 0;
    logic [63:0] sh = '0;
    int          cexp [4] = '{0, 0, 0, 0};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t = 0;
            for (int n = 0; n < 4; n++) cexp[n] = 0;
        end else if (t == 0) begin
            if (start_v[0]) begin
                t  = 1;
                sh = operands;
            end
        end else begin
            if (t >= 9 && t <= 8 + 4 * S0 && ((t - 8) % S0) == 0)
                cexp[(t - 9) / S0] = c_entry(sh, (t - 9) / S0);
            t = (t == 9 + 4 * S0) ? 0 : t + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("rst_busy", 32'(busy_v[0]), 32'd0);
            chk("rst_done", 32'(done_v[0]), 32'd0);
            chk("rst_exec", 32'(mm_execute_v[0]), 32'd1);
            chk("rst_sel_in", 32'(mm_sel_in_v[0]), 32'd0);
            chk("rst_val", 32'(mm_input_val_v[0]), 32'd0);
            chk("rst_sel_out", 32'(mm_sel_out_v[0]), 32'd0);
            chk("rst_c00", 32'(c00_v[0]), 32'd0);
            chk("rst_c11", 32'(c11_v[0]), 32'd0);
        end else begin
            chk("busy", 32'(busy_v[0]), 32'(t >= 1 && t <= 8 + 4 * S0));
            chk("done", 32'(done_v[0]), 32'(t == 9 + 4 * S0));
            chk("execute", 32'(mm_execute_v[0]), 32'(!(t >= 1 && t <= 8)));
            if (t >= 1 && t <= 8) begin
                chk("sel_in", 32'(mm_sel_in_v[0]), 32'(t - 1));
                chk("input_val", 32'(mm_input_val_v[0]), 32'(byte_of(sh, t - 1)));
            end
            if (t >= 9 && t <= 8 + 4 * S0) chk("sel_out", 32'(mm_sel_out_v[0]), 32'((t - 9) / S0));
            else chk("sel_out_idle", 32'(mm_sel_out_v[0]), 32'd0);
            chk("c00", 32'(c00_v[0]), 32'(cexp[0]));
            chk("c01", 32'(c01_v[0]), 32'(cexp[1]));
            chk("c10", 32'(c10_v[0]), 32'(cexp[2]));
            chk("c11", 32'(c11_v[0]), 32'(cexp[3]));
        end
    end

    // Pulses start on one build and returns the cycle (after acceptance) in which done was seen, -1 if never.
    task automatic run(input int idx, input logic [63:0] ops, input bit repulse,
                       output int cyc_done, output logic [15:0] tr);
        int ndone;
        ndone    = 0;
        cyc_done = -1;
        tr       = '0;
        @(negedge clk);
        operands     = ops;
        start_v[idx] = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start_v[idx] = repulse && (cyc == 3 || cyc == 12);
            if (repulse && cyc == 2) operands = '0;
            if (cyc >= 9 && cyc <= 16) tr = {tr[13:0], mm_sel_out_v[idx]};
            if (done_v[idx]) begin
                ndone++;
                if (cyc_done < 0) cyc_done = cyc;
                if (repulse) start_v[idx] = 1'b1;
            end
            if (!repulse && cyc_done >= 0) break;
        end
        start_v[idx] = 1'b0;
        if (repulse) chk("done_pulses", 32'(ndone), 32'd1);
    endtask

    int          dcyc;
    logic [15:0] trace;

    initial begin
        reset    = 1'b0;
        operands = '0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("lit_rst_exec", 32'(mm_execute_v[0]), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run(0, pack(1, 0, 0, 1, 2, 3, 4, 5), 1'b0, dcyc, trace);
        chk("s2_done_cycle", 32'(dcyc), 32'd17);
        chk("s2_trace", 32'(trace), 32'h05AF);
        chk("lit_c00", 32'(c00_v[0]), 32'd2);
        chk("lit_c01", 32'(c01_v[0]), 32'd3);
        chk("lit_c10", 32'(c10_v[0]), 32'd4);
        chk("lit_c11", 32'(c11_v[0]), 32'd5);

        run(0, {64{1'b1}}, 1'b0, dcyc, trace);
        chk("max_done_cycle", 32'(dcyc), 32'd17);
        chk("max_c00", 32'(c00_v[0]), 32'd130050);
        chk("max_c11", 32'(c11_v[0]), 32'd130050);

        run(0, pack(2, 0, 1, 3, 1, 4, 2, 5), 1'b1, dcyc, trace);
        chk("rep_done_cycle", 32'(dcyc), 32'd17);
        chk("rep_c00", 32'(c00_v[0]), 32'd2);
        chk("rep_c01", 32'(c01_v[0]), 32'd8);
        chk("rep_c10", 32'(c10_v[0]), 32'd7);
        chk("rep_c11", 32'(c11_v[0]), 32'd19);

        @(negedge clk);
        operands   = pack(9, 9, 9, 9, 9, 9, 9, 9);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_exec", 32'(mm_execute_v[0]), 32'd1);
        chk("midrst_sel_in", 32'(mm_sel_in_v[0]), 32'd0);
        chk("midrst_val", 32'(mm_input_val_v[0]), 32'd0);
        chk("midrst_c00", 32'(c00_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run(0, pack(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, dcyc, trace);
        chk("post_done_cycle", 32'(dcyc), 32'd17);
        chk("post_c00", 32'(c00_v[0]), 32'd19);
        chk("post_c01", 32'(c01_v[0]), 32'd22);
        chk("post_c10", 32'(c10_v[0]), 32'd43);
        chk("post_c11", 32'(c11_v[0]), 32'd50);

        run(1, pack(1, 0, 0, 1, 2, 3, 4, 5), 1'b0, dcyc, trace);
        chk("s1_done_cycle", 32'(dcyc), 32'd13);
        chk("s1_c00", 32'(c00_v[1]), 32'd2);
        chk("s1_c01", 32'(c01_v[1]), 32'd3);
        chk("s1_c10", 32'(c10_v[1]), 32'd4);
        chk("s1_c11", 32'(c11_v[1]), 32'd5);

        run(2, pack(1, 0, 0, 1, 2, 3, 4, 5), 1'b0, dcyc, trace);
        chk("s5_done_cycle", 32'(dcyc), 32'd29);
        chk("s5_c00", 32'(c00_v[2]), 32'd2);
        chk("s5_c01", 32'(c01_v[2]), 32'd3);
        chk("s5_c10", 32'(c10_v[2]), 32'd4);
        chk("s5_c11", 32'(c11_v[2]), 32'd5);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_pin_driver.md
Name: matmul_pin_driver

Overview:
Host-side initiator for the 2x2 matrix-multiply pin protocol: sel_in/input_val/execute for loading, sel_out/result for readback. On a start pulse it captures eight 8-bit operands and writes them into the multiplier, one per cycle, with execute low. It then raises execute, steps sel_out through all four product entries and captures each 17-bit result into local registers. It sits on the controlling side of the GPIO pins (test chip or FPGA harness) and shares clk with the multiplier.

Parameters:
SETTLE_CYCLES, 2, cycles each sel_out value is held before result is sampled; legal range 1..15.

Ports:
clk  input  1  clock, shared with multiplier
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request; accepted only in IDLE
operands  input  64  byte k at [8k+7:8k]; k=0..7 = A00,A01,A10,A11,B00,B01,B10,B11
busy  output  1  high in LOAD and READ
done  output  1  one-cycle pulse when c00..c11 are updated
c00  output  17  captured C[0][0]
c01  output  17  captured C[0][1]
c10  output  17  captured C[1][0]
c11  output  17  captured C[1][1]
mm_sel_in  output  3  operand slot select to multiplier
mm_input_val  output  8  operand byte to multiplier
mm_execute  output  1  0 = load enabled, 1 = hold operands and drive result
mm_sel_out  output  2  result select: 0=C00, 1=C01, 2=C10, 3=C11
mm_result  input  17  result from multiplier (zero when execute=0)

Behaviour:
- Reset values (async, reset=0): state IDLE, busy 0, done 0, c00..c11 0, mm_sel_in 0, mm_input_val 0, mm_execute 1, mm_sel_out 0, internal counters 0, operand shadow 0.
- mm_execute is 1 in every state except LOAD. This freezes multiplier operands whenever the driver is not loading.
- States: IDLE, LOAD, READ, DONE.
- IDLE:
  - start=1 at a clock edge: capture operands into the shadow register, clear the slot index, go to LOAD.
  - start=0: stay in IDLE.
- LOAD (exactly 8 cycles, slot k=0..7):
  - Drive mm_execute=0, mm_sel_in=k, mm_input_val=shadow byte k, all from registers.
  - The multiplier writes slot k at the edge ending that cycle.
  - After k=7, go to READ with mm_execute=1, mm_sel_out=0, settle counter 0.
- READ (4 x SETTLE_CYCLES cycles):
  - Each index n=0..3 holds mm_sel_out=n for SETTLE_CYCLES cycles.
  - At the edge ending the last of those cycles, register mm_result into c[n].
  - After n<3, increment mm_sel_out. After n=3, go to DONE.
- DONE (1 cycle): done=1, busy=0, mm_sel_out returns to 0; next state IDLE.
- c00..c11 change only at READ capture edges and hold between runs. During READ, already-captured entries show new values while later entries show the previous run; consumers read on done.
- Latency with start accepted at edge E0: LOAD occupies cycles 1..8, READ cycles 9..8+4S, done high in cycle 9+4S (S=2 gives done in cycle 17).
- start while busy or in DONE: ignored, no effect on the run in progress, not queued.
- operands changing after acceptance: no effect (shadow register).
- Reset asserted mid-LOAD or mid-READ: immediate return to reset values; no done pulse; c00..c11 cleared; partially written multiplier operands are not restored.
- Widths: mm_result is captured verbatim, 17 bits, no truncation. Counters are sized for 8 slots and for SETTLE_CYCLES.
- All pin outputs are driven straight from flops, with no combinational path from start or operands.

Test Plan:
- A=I (1,0,0,1), B=(2,3,4,5), S=2, driver connected to the existing matrix_multiply -> done in cycle 17 after start; c00=2, c01=3, c10=4, c11=5.
- All operands 255 -> c00=c01=c10=c11=130050 (0x1FC02), no 17-bit overflow.
- Pin trace check -> in LOAD cycles 1..8, mm_execute=0 and mm_sel_in=0..7 in order, with matching bytes. mm_execute=1 in IDLE/READ/DONE. mm_sel_out=0,0,1,1,2,2,3,3 over READ.
- start re-pulsed at cycles 3 and 12, and in the DONE cycle -> ignored: single done pulse, results from the first operand set only.
- Reset pulled low in LOAD cycle 5, released, new start with A=(1,2,3,4), B=(5,6,7,8) -> reset values seen immediately; second run gives c00=19, c01=22, c10=43, c11=50.
- SETTLE_CYCLES=1 and =5 builds, same vectors as the first scenario -> done in cycles 13 and 29 respectively; identical results.
